// File: rtl/reg_select_encode_if.sv
// ============================================================================
// Module      : reg_select_encode_if
// Description : Control-unit to select/encode bus; controls in, register-file
//               enables and status out.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface reg_select_encode_if #(
    parameter int NREGS = 16,
    parameter int IR_W  = 32
);
    localparam int c_IDX_W = $clog2(NREGS);

    logic                ir_load;
    logic [IR_W-1:0]     IRin;
    logic                Gra;
    logic                Grb;
    logic                Grc;
    logic                Rin;
    logic                Rout;
    logic                BAout;
    logic                pend_set;
    logic                pend_clr;
    logic [c_IDX_W-1:0]  pend_idx;

    logic [NREGS-1:0]    registersIn;
    logic [NREGS-1:0]    registersOut;
    logic                r0_zero;
    logic [IR_W-1:0]     CsignExt;
    logic                stall;
    logic                sel_err;

    modport master (
        output ir_load, IRin, Gra, Grb, Grc, Rin, Rout, BAout,
               pend_set, pend_clr, pend_idx,
        input  registersIn, registersOut, r0_zero, CsignExt, stall, sel_err
    );

    modport slave (
        input  ir_load, IRin, Gra, Grb, Grc, Rin, Rout, BAout,
               pend_set, pend_clr, pend_idx,
        output registersIn, registersOut, r0_zero, CsignExt, stall, sel_err
    );
endinterface

`default_nettype wire

// File: rtl/reg_select_encode.sv
// ============================================================================
// Module      : reg_select_encode
// Description : Registered select-and-encode with write-pending scoreboard.
//               Scoreboard built only when SELENC_SCOREBOARD_EN is defined.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module reg_select_encode #(
    parameter int NREGS  = 16,
    parameter int IR_W   = 32,
    parameter int RA_LSB = 23,
    parameter int RB_LSB = 19,
    parameter int RC_LSB = 15,
    parameter int C_W    = 19
) (
    input  wire                  clock,
    input  wire                  clear,
    reg_select_encode_if.slave   bus
);
    localparam int c_IDX_W = $clog2(NREGS);

    logic [IR_W-1:0]    r_ir;
    logic [NREGS-1:0]   r_regs_in;
    logic [NREGS-1:0]   r_regs_out;
    logic               r_r0_zero;
    logic               r_stall;
    logic               r_sel_err;

    logic [c_IDX_W-1:0] w_ra;
    logic [c_IDX_W-1:0] w_rb;
    logic [c_IDX_W-1:0] w_rc;
    logic [c_IDX_W-1:0] w_sel;
    logic               w_multi;
    logic               w_valid;
    logic               w_rd;
    logic [NREGS-1:0]   w_dec;
    logic               w_stall_next;
    logic [NREGS-1:0]   w_regs_in_next;
    logic [NREGS-1:0]   w_regs_out_next;
    logic               w_r0_zero_next;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_ir <= '0;
        end else if (bus.ir_load) begin
            r_ir <= bus.IRin;
        end
    end

    assign w_ra = r_ir[RA_LSB +: c_IDX_W];
    assign w_rb = r_ir[RB_LSB +: c_IDX_W];
    assign w_rc = r_ir[RC_LSB +: c_IDX_W];

    assign w_multi = (bus.Gra & bus.Grb) | (bus.Gra & bus.Grc) | (bus.Grb & bus.Grc);
    assign w_valid = (bus.Gra | bus.Grb | bus.Grc) & ~w_multi;
    assign w_rd    = bus.Rout | bus.BAout;

    always_comb begin
        w_sel = '0;
        if (bus.Gra) begin
            w_sel = w_ra;
        end else if (bus.Grb) begin
            w_sel = w_rb;
        end else if (bus.Grc) begin
            w_sel = w_rc;
        end
    end

    always_comb begin
        w_dec = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_dec[i] = w_valid && (w_sel == c_IDX_W'(i));
        end
    end

`ifdef SELENC_SCOREBOARD_EN
    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_next;

    // Clear is applied first so a same-index set overrides it.
    always_comb begin
        w_pend_next = r_pend;
        if (bus.pend_clr) begin
            w_pend_next[bus.pend_idx] = 1'b0;
        end
        if (bus.pend_set && w_valid) begin
            w_pend_next[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    assign w_stall_next = w_rd && w_valid && r_pend[w_sel];
`else
    wire w_unused_pend = ^{bus.pend_set, bus.pend_clr, bus.pend_idx};
    assign w_stall_next = 1'b0;
`endif

    // Invalid selections already yield an all-zero w_dec.
    assign w_regs_in_next  = w_dec & {NREGS{bus.Rin}};
    assign w_regs_out_next = w_stall_next ? '0 : (w_dec & {NREGS{w_rd}});
    assign w_r0_zero_next  = bus.BAout && w_valid && (w_sel == '0) && !w_stall_next;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_regs_in  <= '0;
            r_regs_out <= '0;
            r_r0_zero  <= 1'b0;
            r_stall    <= 1'b0;
            r_sel_err  <= 1'b0;
        end else begin
            r_regs_in  <= w_regs_in_next;
            r_regs_out <= w_regs_out_next;
            r_r0_zero  <= w_r0_zero_next;
            r_stall    <= w_stall_next;
            r_sel_err  <= r_sel_err | w_multi;
        end
    end

    wire w_unused_ir = ^r_ir;

    assign bus.registersIn  = r_regs_in;
    assign bus.registersOut = r_regs_out;
    assign bus.r0_zero      = r_r0_zero;
    assign bus.stall        = r_stall;
    assign bus.sel_err      = r_sel_err;
    assign bus.CsignExt     = {{(IR_W-C_W){r_ir[C_W-1]}}, r_ir[C_W-1:0]};

endmodule

`default_nettype wire

// File: tb/tb_reg_select_encode.sv
// ============================================================================
// Module      : tb_reg_select_encode
// Description : Directed bench driving a 16-register and a 32-register instance.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_select_encode;
`ifdef SELENC_SCOREBOARD_EN
    localparam bit c_SB = 1'b1;
`else
    localparam bit c_SB = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        ir_load = 0, gra = 0, grb = 0, grc = 0, rin = 0, rout = 0, baout = 0;
    logic        pset = 0, pclr = 0;
    logic [4:0]  pidx = '0;
    logic [31:0] ir16 = '0, ir32 = '0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clock = ~clock;

    reg_select_encode_if #(.NREGS(16), .IR_W(32)) bus16 ();
    reg_select_encode_if #(.NREGS(32), .IR_W(32)) bus32 ();

    assign bus16.ir_load = ir_load;  assign bus32.ir_load = ir_load;
    assign bus16.IRin    = ir16;     assign bus32.IRin    = ir32;
    assign bus16.Gra     = gra;      assign bus32.Gra     = gra;
    assign bus16.Grb     = grb;      assign bus32.Grb     = grb;
    assign bus16.Grc     = grc;      assign bus32.Grc     = grc;
    assign bus16.Rin     = rin;      assign bus32.Rin     = rin;
    assign bus16.Rout    = rout;     assign bus32.Rout    = rout;
    assign bus16.BAout   = baout;    assign bus32.BAout   = baout;
    assign bus16.pend_set = pset;    assign bus32.pend_set = pset;
    assign bus16.pend_clr = pclr;    assign bus32.pend_clr = pclr;
    assign bus16.pend_idx = pidx[3:0];
    assign bus32.pend_idx = pidx;

    reg_select_encode #(.NREGS(16), .IR_W(32), .RA_LSB(23), .RB_LSB(19), .RC_LSB(15), .C_W(19))
        u_dut16 (.clock(clock), .clear(clear), .bus(bus16));
    reg_select_encode #(.NREGS(32), .IR_W(32), .RA_LSB(22), .RB_LSB(17), .RC_LSB(12), .C_W(17))
        u_dut32 (.clock(clock), .clear(clear), .bus(bus32));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        {ir_load, gra, grb, grc, rin, rout, baout, pset, pclr} = '0;
        pidx = '0;
    endtask

    initial begin
        repeat (3) tick();
        check("rst_rin16",   32'(bus16.registersIn),  32'h0);
        check("rst_rout16",  32'(bus16.registersOut), 32'h0);
        check("rst_cs16",    bus16.CsignExt,          32'h0);
        check("rst_err16",   32'(bus16.sel_err),      32'h0);
        check("rst_stall16", 32'(bus16.stall),        32'h0);
        check("rst_r0z16",   32'(bus16.r0_zero),      32'h0);
        check("rst_rout32",  bus32.registersOut,      32'h0);
        check("rst_cs32",    bus32.CsignExt,          32'h0);
        clear = 1'b1;

        // ra/rb/rc = 2/3/15 (16 regs), 4/15/31 (32 regs)
        tick();
        ir_load = 1; ir16 = 32'h691FFFFD; ir32 = 32'h691FFFFD;
        tick();
        idle(); grb = 1; rout = 1;
        tick();
        check("grb_rout16", 32'(bus16.registersOut), 32'h0000_0008);
        check("grb_rin16",  32'(bus16.registersIn),  32'h0);
        check("cs_neg16",   bus16.CsignExt,          32'hFFFF_FFFD);
        check("grb_rout32", bus32.registersOut,      32'h0000_8000);
        check("cs_neg32",   bus32.CsignExt,          32'hFFFF_FFFD);

        idle(); gra = 1; rin = 1;
        tick();
        check("gra_rin16",  32'(bus16.registersIn),  32'h0000_0004);
        check("gra_rout16", 32'(bus16.registersOut), 32'h0);
        check("gra_rin32",  bus32.registersIn,       32'h0000_0010);

        idle(); grc = 1; rout = 1;
        tick();
        check("grc_rout16", 32'(bus16.registersOut), 32'h0000_8000);
        check("grc_rout32", bus32.registersOut,      32'h8000_0000);

        // Decode in the load cycle still sees the old instruction
        idle(); ir_load = 1; ir16 = '0; ir32 = '0; gra = 1; rin = 1;
        tick();
        check("oldir_rin16", 32'(bus16.registersIn), 32'h0000_0004);
        check("oldir_rin32", bus32.registersIn,      32'h0000_0010);
        idle();
        tick();
        check("cs_zero16", bus16.CsignExt, 32'h0);

        idle(); gra = 1; grb = 1; rin = 1; rout = 1;
        tick();
        check("multi_rin16",  32'(bus16.registersIn),  32'h0);
        check("multi_rout16", 32'(bus16.registersOut), 32'h0);
        check("multi_err16",  32'(bus16.sel_err),      32'h1);
        check("multi_rout32", bus32.registersOut,      32'h0);
        check("multi_err32",  32'(bus32.sel_err),      32'h1);

        idle(); grc = 1; rout = 1; ir_load = 1; ir16 = 32'h691FFFFD; ir32 = 32'h691FFFFD;
        tick();
        check("sticky_err16", 32'(bus16.sel_err),      32'h1);
        check("r0_rout16",    32'(bus16.registersOut), 32'h0000_0001);
        check("ld_cs16",      bus16.CsignExt,          32'hFFFF_FFFD);
        idle();
        clear = 1'b0;
        #2;
        check("aclr_rout16", 32'(bus16.registersOut), 32'h0);
        check("aclr_err16",  32'(bus16.sel_err),      32'h0);
        check("aclr_cs16",   bus16.CsignExt,          32'h0);
        check("aclr_err32",  32'(bus32.sel_err),      32'h0);
        tick();
        clear = 1'b1;

        idle(); ir_load = 1; ir16 = 32'h0003_FFFF; ir32 = 32'h0000_FFFF;
        tick();
        idle(); grb = 1; baout = 1;
        tick();
        check("ba_rout16", 32'(bus16.registersOut), 32'h0000_0001);
        check("ba_r0z16",  32'(bus16.r0_zero),      32'h1);
        check("cs_pos16",  bus16.CsignExt,          32'h0003_FFFF);
        check("ba_rout32", bus32.registersOut,      32'h0000_0001);
        check("ba_r0z32",  32'(bus32.r0_zero),      32'h1);
        check("cs_pos32",  bus32.CsignExt,          32'h0000_FFFF);

        // ra = 2, rb = 0 on both instances
        idle(); ir_load = 1; ir16 = 32'h0100_0000; ir32 = 32'h0080_0000;
        tick();
        idle(); gra = 1; pset = 1;
        tick();
        idle(); gra = 1; rout = 1;
        tick();
        check("pend_stall16", 32'(bus16.stall),        32'(c_SB));
        check("pend_rout16",  32'(bus16.registersOut), c_SB ? 32'h0 : 32'h4);
        check("pend_stall32", 32'(bus32.stall),        32'(c_SB));
        check("pend_rout32",  bus32.registersOut,      c_SB ? 32'h0 : 32'h4);

        idle(); pclr = 1; pidx = 5'd2;
        tick();
        idle(); gra = 1; rout = 1;
        tick();
        check("clr_stall16", 32'(bus16.stall),        32'h0);
        check("clr_rout16",  32'(bus16.registersOut), 32'h4);
        check("clr_stall32", 32'(bus32.stall),        32'h0);

        idle(); gra = 1; pset = 1; pclr = 1; pidx = 5'd2;
        tick();
        idle(); gra = 1; rout = 1;
        tick();
        check("same_stall16", 32'(bus16.stall),        32'(c_SB));
        check("same_rout16",  32'(bus16.registersOut), c_SB ? 32'h0 : 32'h4);
        check("same_stall32", 32'(bus32.stall),        32'(c_SB));

        idle(); grb = 1; pset = 1; pclr = 1; pidx = 5'd2;
        tick();
        idle(); gra = 1; rout = 1;
        tick();
        check("diff_stall_ra16", 32'(bus16.stall),        32'h0);
        check("diff_rout_ra16",  32'(bus16.registersOut), 32'h4);
        idle(); grb = 1; baout = 1;
        tick();
        check("diff_stall_r016", 32'(bus16.stall),        32'(c_SB));
        check("diff_rout_r016",  32'(bus16.registersOut), c_SB ? 32'h0 : 32'h1);
        check("diff_r0z16",      32'(bus16.r0_zero),      c_SB ? 32'h0 : 32'h1);
        check("diff_stall_r032", 32'(bus32.stall),        32'(c_SB));

        idle();
        clear = 1'b0;
        #2;
        check("aclr2_stall16", 32'(bus16.stall),        32'h0);
        check("aclr2_rout16",  32'(bus16.registersOut), 32'h0);
        check("aclr2_r0z16",   32'(bus16.r0_zero),      32'h0);
        check("aclr2_stall32", 32'(bus32.stall),        32'h0);
        tick();
        clear = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
